multicycle_ctrl_fsm: RTL and testbench

//  Multicycle main controller for the 2-bit-Op ISA (DP / LDR-STR / B). It sequences the shared ALU, memory port
//  and register file over several cycles per instruction using a Moore FSM and a valid/ready memory handshake.
//  It decodes Funct[4:1] to ALUControl and produces all datapath mux selects and write strobes.
//  It sits between the instruction register / condition unit and the multicycle datapath.

---
 rtl/multicycle_ctrl_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle main controller: Moore FSM sequencing ALU, memory and register file for DP / LDR-STR / B.
// Optional performance counters are built when MCFSM_PERF_EN is defined.
//
// state  | meaning
// FETCH  | read instruction at PC; on mem_ready load IR and PC += 4
// DECODE | read registers, ALU computes PC+8; dispatch on op / cond_ex
// MEMADR | ALU computes base + offset
// MEMRD  | load access, held until mem_ready
// MEMWR  | store access, held until mem_ready
// MEMWB  | write loaded data to rd
// EXECR  | ALU op on RD1, RD2
// EXECI  | ALU op on RD1, ExtImm
// ALUWB  | write ALU result to rd
// BRANCH | PC <= PC+8 + offset
module multicycle_ctrl_fsm #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        rd,
  input  logic              cond_ex,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_w,
  output logic              ir_write,
  output logic              adr_src,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        result_src,
  output logic [1:0]        alu_control,
  output logic [1:0]        flag_w,
  output logic              reg_w,
  output logic              pc_write,
  output logic              illegal,
  output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_instr
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t state_q, state_d;

  logic [1:0] alu_dec;
  logic       cmd_ok;
  logic       is_addsub;
  logic [1:0] flag_dec;
  logic       rd_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    alu_dec = 2'b00;
    cmd_ok  = 1'b1;
    case (funct[4:1])
      4'b0100: alu_dec = 2'b00;
      4'b0010: alu_dec = 2'b01;
      4'b0001: alu_dec = 2'b10;
      4'b1111: alu_dec = 2'b11;
      default: cmd_ok  = 1'b0;
    endcase
  end

  assign is_addsub = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010);
  assign flag_dec  = {funct[0], funct[0] & is_addsub};
  assign rd_pc     = (rd == 4'hF);

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_w       = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 2'b00;
    flag_w      = 2'b00;
    reg_w       = 1'b0;
    pc_write    = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          pc_write   = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (!cond_ex) begin
          state_d = FETCH;
        end else begin
          case (op)
            2'b01:   state_d = MEMADR;
            2'b00:   state_d = funct[5] ? EXECI : EXECR;
            2'b10:   state_d = BRANCH;
            default: begin
              illegal = 1'b1;
              state_d = FETCH;
            end
          endcase
        end
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_w   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        pc_write   = rd_pc;
        state_d    = FETCH;
      end
      EXECR, EXECI: begin
        alu_src_b   = (state_q == EXECI) ? 2'b01 : 2'b00;
        alu_control = alu_dec;
        flag_w      = flag_dec;
        state_d     = ALUWB;
      end
      ALUWB: begin
        // undefined commands retire as NOPs: no register or PC write
        alu_control = alu_dec;
        reg_w       = cmd_ok;
        pc_write    = cmd_ok & rd_pc;
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // outputs are forced quiet for the whole time reset is held
    if (!rst_n) begin
      mem_req     = 1'b0;
      mem_w       = 1'b0;
      ir_write    = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      alu_control = 2'b00;
      flag_w      = 2'b00;
      reg_w       = 1'b0;
      pc_write    = 1'b0;
      illegal     = 1'b0;
    end
  end

`ifdef MCFSM_PERF_EN
  logic [PERF_W-1:0] cycles_q;
  logic [PERF_W-1:0] instr_q;
  logic              retire;

  assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BRANCH) ||
                  ((state_q == MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= '0;
      instr_q  <= '0;
    end else begin
      cycles_q <= cycles_q + 1'b1;
      if (retire) instr_q <= instr_q + 1'b1;
    end
  end

  assign perf_cycles = cycles_q;
  assign perf_instr  = instr_q;
`else
  assign perf_cycles = '0;
  assign perf_instr  = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: stimulus queues expected output vectors, a monitor compares them.
module tb_multicycle_ctrl_fsm;
  localparam int PERF_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        op;
  logic [5:0]        funct;
  logic [3:0]        rd;
  logic              cond_ex;
  logic              mem_ready;
  logic              mem_req, mem_w, ir_write, adr_src, alu_src_a;
  logic [1:0]        alu_src_b, result_src, alu_control, flag_w;
  logic              reg_w, pc_write, illegal;
  logic [PERF_W-1:0] perf_cycles, perf_instr;

  multicycle_ctrl_fsm #(.PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rd(rd), .cond_ex(cond_ex),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_w(mem_w), .ir_write(ir_write),
    .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_control(alu_control), .flag_w(flag_w),
    .reg_w(reg_w), .pc_write(pc_write), .illegal(illegal),
    .perf_cycles(perf_cycles), .perf_instr(perf_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] act;

  assign act = {mem_req, mem_w, ir_write, adr_src, alu_src_a, alu_src_b,
                result_src, alu_control, flag_w, reg_w, pc_write, illegal};

  function automatic logic [15:0] mk(input bit req, input bit w, input bit irw, input bit adr,
                                     input bit sa, input bit [1:0] sb, input bit [1:0] rs,
                                     input bit [1:0] ac, input bit [1:0] fw, input bit rw,
                                     input bit pcw, input bit ill);
    return {req, w, irw, adr, sa, sb, rs, ac, fw, rw, pcw, ill};
  endfunction

  logic [15:0] f_wait, f_go, dec, madr, mrd, mwr, zero;

  task automatic step(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                      input logic ce, input logic mr, input logic [15:0] e, input string tag);
    op = o; funct = f; rd = r; cond_ex = ce; mem_ready = mr;
    sbq.push_back('{e, tag});
    @(posedge clk); #1;
  endtask

  task automatic check_val(input string tag, input logic [PERF_W-1:0] got, input logic [PERF_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // monitor: outputs are presented every cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got %b expected %b", e.tag, act, e.v);
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int exp_instr;
    f_wait = mk(1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
    f_go   = mk(1,0,1,0,1,2'b10,2'b10,2'b00,2'b00,0,1,0);
    dec    = mk(0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,0,0,0);
    madr   = mk(0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,0,0,0);
    mrd    = mk(1,0,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
    mwr    = mk(1,1,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
    zero   = '0;

    rst_n = 1'b0; op = 2'b00; funct = '0; rd = '0; cond_ex = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    check_val("reset_perf_cycles", perf_cycles, 0);
    check_val("reset_perf_instr", perf_instr, 0);
    step(2'b00, 6'b000000, 4'd0, 1'b1, 1'b1, zero, "reset_outputs");
    rst_n = 1'b1;

    // ADD, I=0, S=1, rd=3
    step(2'b00, 6'b001001, 4'd3, 1'b1, 1'b1, f_go, "add_fetch");
    step(2'b00, 6'b001001, 4'd3, 1'b1, 1'b1, dec, "add_decode");
    step(2'b00, 6'b001001, 4'd3, 1'b1, 1'b1, mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b11,0,0,0), "add_execr");
    step(2'b00, 6'b001001, 4'd3, 1'b1, 1'b1, mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0,0), "add_aluwb");

    // SUB immediate, S=0, rd=15
    step(2'b00, 6'b100100, 4'd15, 1'b1, 1'b1, f_go, "sub_fetch");
    step(2'b00, 6'b100100, 4'd15, 1'b1, 1'b1, dec, "sub_decode");
    step(2'b00, 6'b100100, 4'd15, 1'b1, 1'b1, mk(0,0,0,0,0,2'b01,2'b00,2'b01,2'b00,0,0,0), "sub_execi");
    step(2'b00, 6'b100100, 4'd15, 1'b1, 1'b1, mk(0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,1,1,0), "sub_aluwb");

    // XOR, S=1 (no C/V update), rd=2
    step(2'b00, 6'b000011, 4'd2, 1'b1, 1'b1, f_go, "xor_fetch");
    step(2'b00, 6'b000011, 4'd2, 1'b1, 1'b1, dec, "xor_decode");
    step(2'b00, 6'b000011, 4'd2, 1'b1, 1'b1, mk(0,0,0,0,0,2'b00,2'b00,2'b10,2'b10,0,0,0), "xor_execr");
    step(2'b00, 6'b000011, 4'd2, 1'b1, 1'b1, mk(0,0,0,0,0,2'b00,2'b00,2'b10,2'b00,1,0,0), "xor_aluwb");

    // undefined command 1000 -> NOP, no register write
    step(2'b00, 6'b010000, 4'd4, 1'b1, 1'b1, f_go, "nop_fetch");
    step(2'b00, 6'b010000, 4'd4, 1'b1, 1'b1, dec, "nop_decode");
    step(2'b00, 6'b010000, 4'd4, 1'b1, 1'b1, zero, "nop_execr");
    step(2'b00, 6'b010000, 4'd4, 1'b1, 1'b1, zero, "nop_aluwb");

    // LDR rd=15 with two wait cycles
    step(2'b01, 6'b000001, 4'd15, 1'b1, 1'b1, f_go, "ldr_fetch");
    step(2'b01, 6'b000001, 4'd15, 1'b1, 1'b1, dec, "ldr_decode");
    step(2'b01, 6'b000001, 4'd15, 1'b1, 1'b1, madr, "ldr_memadr");
    step(2'b01, 6'b000001, 4'd15, 1'b1, 1'b0, mrd, "ldr_memrd_wait1");
    step(2'b01, 6'b000001, 4'd15, 1'b1, 1'b0, mrd, "ldr_memrd_wait2");
    step(2'b01, 6'b000001, 4'd15, 1'b1, 1'b1, mrd, "ldr_memrd_done");
    step(2'b01, 6'b000001, 4'd15, 1'b1, 1'b1, mk(0,0,0,0,0,2'b00,2'b01,2'b00,2'b00,1,1,0), "ldr_memwb");

    // STR, no waits
    step(2'b01, 6'b000000, 4'd5, 1'b1, 1'b1, f_go, "str_fetch");
    step(2'b01, 6'b000000, 4'd5, 1'b1, 1'b1, dec, "str_decode");
    step(2'b01, 6'b000000, 4'd5, 1'b1, 1'b1, madr, "str_memadr");
    step(2'b01, 6'b000000, 4'd5, 1'b1, 1'b1, mwr, "str_memwr");

    // branch squashed by cond_ex=0
    step(2'b10, 6'b000000, 4'd0, 1'b0, 1'b1, f_go, "bsq_fetch");
    step(2'b10, 6'b000000, 4'd0, 1'b0, 1'b1, dec, "bsq_decode");

    // branch taken
    step(2'b10, 6'b000000, 4'd0, 1'b1, 1'b1, f_go, "b_fetch");
    step(2'b10, 6'b000000, 4'd0, 1'b1, 1'b1, dec, "b_decode");
    step(2'b10, 6'b000000, 4'd0, 1'b1, 1'b1, mk(0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,0,1,0), "b_branch");

    // illegal op after one fetch wait cycle
    step(2'b11, 6'b000000, 4'd0, 1'b1, 1'b0, f_wait, "ill_fetch_wait");
    step(2'b11, 6'b000000, 4'd0, 1'b1, 1'b1, f_go, "ill_fetch");
    step(2'b11, 6'b000000, 4'd0, 1'b1, 1'b1, mk(0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,0,0,1), "ill_decode");

`ifdef MCFSM_PERF_EN
    exp_instr = 7;
`else
    exp_instr = 0;
`endif
    check_val("perf_instr_retired", perf_instr, exp_instr);

    // STR interrupted by reset while waiting in MEMWR
    step(2'b01, 6'b000000, 4'd5, 1'b1, 1'b1, f_go, "rst_str_fetch");
    step(2'b01, 6'b000000, 4'd5, 1'b1, 1'b1, dec, "rst_str_decode");
    step(2'b01, 6'b000000, 4'd5, 1'b1, 1'b1, madr, "rst_str_memadr");
    step(2'b01, 6'b000000, 4'd5, 1'b1, 1'b0, mwr, "rst_str_memwr_wait");
    rst_n = 1'b0;
    step(2'b01, 6'b000000, 4'd5, 1'b1, 1'b1, zero, "rst_mid_outputs");
    check_val("rst_mid_perf_cycles", perf_cycles, 0);
    rst_n = 1'b1;
    step(2'b01, 6'b000000, 4'd5, 1'b1, 1'b0, f_wait, "post_rst_fetch_wait");
    step(2'b01, 6'b000000, 4'd5, 1'b1, 1'b1, f_go, "post_rst_fetch");

    @(negedge clk); #1;
    check_val("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
